// File: rtl/rr_arbiter_4ch.sv
// Four-requester round-robin arbiter. The grant is registered and held until its owner releases it.
// Optional owner preemption after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_4ch #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] owner_oh, cand;
  logic [1:0] win, scan;
  logic       win_vld, grant_new, preempt;

  assign owner_oh = 4'b0001 << ptr_q;
  // While granted, the owner only competes once it has released, so masking it is harmless.
  assign cand     = (state_q == GRANT) ? (req & ~owner_oh) : req;

  // Scan runs from farthest to nearest, so the nearest set bit after ptr wins.
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    scan    = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      scan = ptr_q + 2'(k);
      if (cand[scan]) begin
        win     = scan;
        win_vld = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign preempt = (state_q == GRANT) && req[ptr_q] && win_vld &&
                   (cnt_q == 8'(MAX_HOLD - 1));

  // The count saturates while nobody else is waiting, so rotation happens on the first contender.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_d != gnt_q)
      cnt_d = '0;
    else if (state_q == GRANT && cnt_q != 8'(MAX_HOLD - 1))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    grant_new = 1'b0;
    case (state_q)
      IDLE: grant_new = win_vld;
      GRANT: begin
        if (!req[ptr_q]) begin
          if (win_vld) grant_new = 1'b1;
          else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (preempt) begin
          grant_new = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_new) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win;
      idx_d   = win;
      ptr_d   = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      idx_q   <= 2'd0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;

endmodule
